// File: rtl/acumulador_selectivo_param.sv
// Parametrised selective accumulator.
// Stage 1 registers a signed combination of two unsigned operands chosen by
// i_sel; stage 2 adds it into a signed running accumulator with wrap or
// saturate overflow handling, a sticky overflow flag and a sample counter.
// Ports:
//   clock      - single clock, rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_valid    - operands/selector valid this cycle
//   i_clear    - synchronous clear of accumulator, counter and sticky flag
//   i_sel      - 00:a+b 01:a-b 10:a 11:-(a+b)
//   i_data1/2  - unsigned operands a/b
//   o_data     - accumulator value (signed)
//   o_valid    - one-cycle strobe when o_data holds a new sample
//   o_overflow - sticky overflow flag
//   o_count    - samples accumulated since last clear/reset (saturating)
module acumulador_selectivo_param #(
    parameter int unsigned NB_DATA  = 3,
    parameter int unsigned NB_ACC   = 6,
    parameter int unsigned NB_CNT   = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic                clock,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic                i_clear,
    input  logic [1:0]          i_sel,
    input  logic [NB_DATA-1:0]  i_data1,
    input  logic [NB_DATA-1:0]  i_data2,
    output logic [NB_ACC-1:0]   o_data,
    output logic                o_valid,
    output logic                o_overflow,
    output logic [NB_CNT-1:0]   o_count
);

    localparam int unsigned NB_OP  = NB_DATA + 2;
    localparam int unsigned NB_SUM = NB_ACC + 1;

    localparam logic [NB_ACC-1:0] ACC_MAX = {1'b0, {(NB_ACC-1){1'b1}}};
    localparam logic [NB_ACC-1:0] ACC_MIN = {1'b1, {(NB_ACC-1){1'b0}}};

    logic [NB_OP-1:0]  w_a;
    logic [NB_OP-1:0]  w_b;
    logic [NB_OP-1:0]  w_op;
    logic [NB_OP-1:0]  r_op;
    logic              r_v1;

    logic [NB_ACC-1:0] r_acc;
    logic [NB_CNT-1:0] r_cnt;
    logic              r_ovf;
    logic              r_valid;

    logic [NB_ACC-1:0] w_acc_base;
    logic [NB_CNT-1:0] w_cnt_base;
    logic              w_ovf_base;
    logic [NB_SUM-1:0] w_sum;
    logic              w_add_ovf;
    logic [NB_ACC-1:0] w_acc_next;
    logic [NB_CNT-1:0] w_cnt_next;

    // Operands widened by two bits so every selector result fits signed.
    assign w_a = NB_OP'(i_data1);
    assign w_b = NB_OP'(i_data2);

    // Operation select
    always_comb begin
        w_op = '0;
        case (i_sel)
            2'b00:   w_op = w_a + w_b;
            2'b01:   w_op = w_a - w_b;
            2'b10:   w_op = w_a;
            default: w_op = NB_OP'(0) - (w_a + w_b);
        endcase
    end

    // Stage 1: operation register; op holds when no sample is accepted
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_op <= w_op;
            end
        end
    end

    // Clear applies the in-flight sample onto zero state
    assign w_acc_base = i_clear ? '0   : r_acc;
    assign w_cnt_base = i_clear ? '0   : r_cnt;
    assign w_ovf_base = i_clear ? 1'b0 : r_ovf;

    // One guard bit: overflow when the top two bits of the sum disagree
    assign w_sum     = {w_acc_base[NB_ACC-1], w_acc_base} + NB_SUM'($signed(r_op));
    assign w_add_ovf = w_sum[NB_SUM-1] ^ w_sum[NB_ACC-1];

    // Overflow direction follows the sign of op (acc alone cannot overflow)
    always_comb begin
        w_acc_next = w_sum[NB_ACC-1:0];
        if (w_add_ovf && (SATURATE != 0)) begin
            w_acc_next = r_op[NB_OP-1] ? ACC_MIN : ACC_MAX;
        end
    end

    assign w_cnt_next = (w_cnt_base == {NB_CNT{1'b1}}) ? w_cnt_base
                                                       : w_cnt_base + NB_CNT'(1);

    // Stage 2: accumulate, count and track overflow
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_v1;
            if (r_v1) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_base | w_add_ovf;
            end else if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_data     = r_acc;
    assign o_valid    = r_valid;
    assign o_overflow = r_ovf;
    assign o_count    = r_cnt;

endmodule

// File: tb/tb_acumulador_selectivo_param.sv
// Bench for acumulador_selectivo_param. Three instances share one stimulus:
//   0: defaults (wrap), 1: SATURATE=1, 2: NB_CNT=2 (wrap).
// An integer-arithmetic model predicts every output each cycle; literal
// sequences from hand calculation pin both the model and the DUTs.
module tb_acumulador_selectivo_param;

    logic       clock;
    logic       rst_n;
    logic       i_valid;
    logic       i_clear;
    logic [1:0] i_sel;
    logic [2:0] i_data1;
    logic [2:0] i_data2;

    logic [5:0] dat0, dat1, dat2;
    logic       v0, v1, v2;
    logic       ov0, ov1, ov2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    acumulador_selectivo_param u_wrap (
        .clock(clock), .i_rst_n(rst_n), .i_valid(i_valid), .i_clear(i_clear),
        .i_sel(i_sel), .i_data1(i_data1), .i_data2(i_data2),
        .o_data(dat0), .o_valid(v0), .o_overflow(ov0), .o_count(cnt0)
    );

    acumulador_selectivo_param #(.SATURATE(1)) u_sat (
        .clock(clock), .i_rst_n(rst_n), .i_valid(i_valid), .i_clear(i_clear),
        .i_sel(i_sel), .i_data1(i_data1), .i_data2(i_data2),
        .o_data(dat1), .o_valid(v1), .o_overflow(ov1), .o_count(cnt1)
    );

    acumulador_selectivo_param #(.NB_CNT(2)) u_cnt (
        .clock(clock), .i_rst_n(rst_n), .i_valid(i_valid), .i_clear(i_clear),
        .i_sel(i_sel), .i_data1(i_data1), .i_data2(i_data2),
        .o_data(dat2), .o_valid(v2), .o_overflow(ov2), .o_count(cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int m_acc [3];
    int m_cnt [3];
    bit m_ovf [3];
    bit m_vld;
    bit m_pv;
    int m_pop;

    function automatic int op_of(input logic [1:0] s, input int a, input int b);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a;
            default: return -(a + b);
        endcase
    endfunction

    function automatic bit add_ovf(input int acc, input int op);
        int s;
        s = acc + op;
        return (s > 31) || (s < -32);
    endfunction

    function automatic int acc_next(input int acc, input int op, input bit sat);
        int s;
        s = acc + op;
        if (s >= -32 && s <= 31) return s;
        if (sat) return (op > 0) ? 31 : -32;
        return (s > 31) ? s - 64 : s + 64;
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 2) ? 3 : 255;
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_pv  <= 1'b0;
            m_pop <= 0;
            m_vld <= 1'b0;
            for (int d = 0; d < 3; d++) begin
                m_acc[d] <= 0;
                m_cnt[d] <= 0;
                m_ovf[d] <= 1'b0;
            end
        end else begin
            m_vld <= m_pv;
            for (int d = 0; d < 3; d++) begin
                if (m_pv) begin
                    m_acc[d] <= acc_next(i_clear ? 0 : m_acc[d], m_pop, d == 1);
                    m_ovf[d] <= (i_clear ? 1'b0 : m_ovf[d]) |
                                add_ovf(i_clear ? 0 : m_acc[d], m_pop);
                    m_cnt[d] <= ((i_clear ? 0 : m_cnt[d]) + 1 > cnt_max(d)) ?
                                cnt_max(d) : (i_clear ? 0 : m_cnt[d]) + 1;
                end else if (i_clear) begin
                    m_acc[d] <= 0;
                    m_cnt[d] <= 0;
                    m_ovf[d] <= 1'b0;
                end
            end
            m_pv <= i_valid;
            if (i_valid) m_pop <= op_of(i_sel, int'(i_data1), int'(i_data2));
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input bit v, input int data,
                             input bit ov, input int cnt);
        chk($sformatf("dut%0d_valid", d), int'(v), int'(m_vld));
        chk($sformatf("dut%0d_data", d), data, m_acc[d]);
        chk($sformatf("dut%0d_ovf", d), int'(ov), int'(m_ovf[d]));
        chk($sformatf("dut%0d_count", d), cnt, m_cnt[d]);
    endtask

    int q0[$];
    int q1[$];
    int q2[$];
    int qc2[$];

    // Compare every cycle, and log o_data on each strobe
    always @(negedge clock) begin
        check_dut(0, v0, int'($signed(dat0)), ov0, int'(cnt0));
        check_dut(1, v1, int'($signed(dat1)), ov1, int'(cnt1));
        check_dut(2, v2, int'($signed(dat2)), ov2, int'(cnt2));
        if (v0) q0.push_back(int'($signed(dat0)));
        if (v1) q1.push_back(int'($signed(dat1)));
        if (v2) begin
            q2.push_back(int'($signed(dat2)));
            qc2.push_back(int'(cnt2));
        end
    end

    task automatic check_seq(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit c, input logic [1:0] s,
                        input int a, input int b);
        @(negedge clock);
        i_valid = v;
        i_clear = c;
        i_sel   = s;
        i_data1 = 3'(a);
        i_data2 = 3'(b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'b00, 0, 0);
    endtask

    task automatic flush_logs();
        #1;
        q0.delete(); q1.delete(); q2.delete(); qc2.delete();
    endtask

    task automatic clear_all();
        step(1'b0, 1'b1, 2'b00, 0, 0);
        idle(2);
        flush_logs();
    endtask

    initial begin
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_sel   = 2'b00;
        i_data1 = 3'd0;
        i_data2 = 3'd0;
        #1 rst_n = 1'b0;

        // Reset held with toggling inputs: outputs must stay zero
        repeat (6) step(1'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(7)),
                        int'($urandom_range(7)));
        chk("rst_data", int'(dat0), 0);
        chk("rst_count", int'(cnt0), 0);
        @(negedge clock);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        flush_logs();
        step(1'b1, 1'b0, 2'b00, 3, 2);
        idle(3);
        #1;
        check_seq("first_sample", q0, '{5});
        chk("first_count", int'(cnt0), 1);

        // Mode sweep, back to back
        clear_all();
        step(1'b1, 1'b0, 2'b00, 5, 3);
        step(1'b1, 1'b0, 2'b01, 5, 3);
        step(1'b1, 1'b0, 2'b10, 5, 3);
        step(1'b1, 1'b0, 2'b11, 5, 3);
        idle(3);
        #1;
        check_seq("sweep_wrap", q0, '{8, 10, 15, 7});
        check_seq("sweep_sat", q1, '{8, 10, 15, 7});
        chk("sweep_count", int'(cnt0), 4);
        chk("sweep_count_nb2", int'(cnt2), 3);

        // Overflow: wrap vs saturate
        clear_all();
        repeat (3) step(1'b1, 1'b0, 2'b00, 7, 7);
        idle(5);
        #1;
        check_seq("wrap_ovf", q0, '{14, 28, -22});
        check_seq("sat_ovf", q1, '{14, 28, 31});
        chk("wrap_sticky", int'(ov0), 1);
        chk("sat_sticky", int'(ov1), 1);
        chk("model_wrap_acc", m_acc[0], -22);
        flush_logs();
        repeat (5) step(1'b1, 1'b0, 2'b11, 7, 7);
        idle(3);
        #1;
        check_seq("sat_down", q1, '{17, 3, -11, -25, -32});
        check_seq("wrap_down", q0, '{28, 14, 0, -14, -28});
        chk("model_sat_acc", m_acc[1], -32);

        // Build acc=20 with sticky flag, then clear meets an in-flight op=6
        flush_logs();
        repeat (3) step(1'b1, 1'b0, 2'b00, 7, 7);
        step(1'b1, 1'b0, 2'b00, 5, 1);
        step(1'b1, 1'b0, 2'b00, 3, 3);
        step(1'b0, 1'b1, 2'b00, 0, 0);
        idle(3);
        #1;
        check_seq("clear_merge", q0, '{-14, 0, 14, 20, 6});
        chk("clear_merge_data_sat", int'($signed(dat1)), 6);
        chk("clear_merge_count", int'(cnt0), 1);
        chk("clear_merge_ovf", int'(ov0), 0);

        // Sample accepted in a clear cycle is kept and lands after the clear
        idle(1);
        step(1'b1, 1'b1, 2'b10, 2, 0);
        idle(3);
        #1;
        chk("clear_keep_data", int'($signed(dat0)), 2);
        chk("clear_keep_count", int'(cnt0), 1);

        // Counter saturation on the 2-bit counter instance
        clear_all();
        repeat (5) step(1'b1, 1'b0, 2'b10, 1, 0);
        idle(3);
        #1;
        check_seq("cnt_sat", qc2, '{1, 2, 3, 3, 3});
        chk("cnt_sat_data", int'($signed(dat2)), 5);

        // Reset mid-pipeline drops the in-flight sample
        flush_logs();
        step(1'b1, 1'b0, 2'b00, 1, 1);
        @(posedge clock);
        #2 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        #1;
        chk("rst_mid_novalid", q0.size(), 0);
        chk("rst_mid_data", int'(dat0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
